// File: rtl/raw_linebuf_7row.sv
// Seven-row raw Bayer line buffer.
// Six cascaded line memories delay the pixel stream by one to six lines, so each
// accepted pixel produces one registered 7-row column (D0 oldest ... D6 current)
// plus parity and window flags for a downstream 7x7 stage.
module raw_linebuf_7row #(
    parameter int IMG_W = 640,
    parameter int ROW_W = 12
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [9:0] in_data,
    output logic [9:0] D0,
    output logic [9:0] D1,
    output logic [9:0] D2,
    output logic [9:0] D3,
    output logic [9:0] D4,
    output logic [9:0] D5,
    output logic [9:0] D6,
    output logic       X,
    output logic       Y,
    output logic       out_valid,
    output logic       win_valid,
    output logic       out_eol
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]    COL_WIN  = CW'(6);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(6);
    localparam logic [ROW_W-1:0] ROW_MAX  = {ROW_W{1'b1}};

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    col;
    logic [ROW_W-1:0] row;

    logic             accept;
    logic [CW-1:0]    cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [CW-1:0]    nxt_col;
    logic [ROW_W-1:0] nxt_row;
    logic [9:0]       rd [0:5];

    // Line k holds the pixel of this column from 6-k lines ago; not reset.
    logic [9:0] line_mem [0:5][0:IMG_W-1];

    // Acceptance, effective position (sof forces col 0 / row 0) and counter next values.
    always_comb begin
        accept  = in_valid & ((state == ST_ACTIVE) | in_sof);
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? '0 : row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_MAX) ? cur_row : cur_row + ROW_W'(1);
        end else begin
            nxt_col = cur_col + CW'(1);
            nxt_row = cur_row;
        end
        for (int k = 0; k < 6; k++) begin
            rd[k] = line_mem[k][cur_col];
        end
    end

    // Frame state and raster counters; counters only move on accepted pixels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else if (accept) begin
            if (in_sof) begin
                state <= ST_ACTIVE;
            end
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Cascade shift of the line memories; reads above see pre-write contents.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int k = 0; k < 5; k++) begin
                line_mem[k][cur_col] <= rd[k+1];
            end
            line_mem[5][cur_col] <= in_data;
        end
    end

    // Registered column outputs; data and parity hold while no pixel is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            D0        <= '0;
            D1        <= '0;
            D2        <= '0;
            D3        <= '0;
            D4        <= '0;
            D5        <= '0;
            D6        <= '0;
            X         <= 1'b0;
            Y         <= 1'b0;
            out_valid <= 1'b0;
            win_valid <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= accept;
            win_valid <= accept & (cur_row >= ROW_WIN) & (cur_col >= COL_WIN);
            out_eol   <= accept & (cur_col == COL_LAST);
            if (accept) begin
                D0 <= rd[0];
                D1 <= rd[1];
                D2 <= rd[2];
                D3 <= rd[3];
                D4 <= rd[4];
                D5 <= rd[5];
                D6 <= in_data;
                // Inverted parity lines up with the centre three columns/rows back.
                X  <= ~cur_col[0];
                Y  <= ~cur_row[0];
            end
        end
    end

endmodule

// File: tb/tb_raw_linebuf_7row.sv
// Scoreboard bench for raw_linebuf_7row: a driver pushes expected columns from a
// per-column pixel-history model; a negedge monitor pops and compares them.
module tb_raw_linebuf_7row;

    localparam int IMG_W   = 8;
    localparam int ROW_W   = 4;
    localparam int ROW_MAX = (1 << ROW_W) - 1;

    logic       CLK;
    logic       RST_N;
    logic       in_valid;
    logic       in_sof;
    logic [9:0] in_data;
    logic [9:0] D0, D1, D2, D3, D4, D5, D6;
    logic       X, Y, out_valid, win_valid, out_eol;
    logic [9:0] dq [7];

    assign dq[0] = D0;
    assign dq[1] = D1;
    assign dq[2] = D2;
    assign dq[3] = D3;
    assign dq[4] = D4;
    assign dq[5] = D5;
    assign dq[6] = D6;

    raw_linebuf_7row #(.IMG_W(IMG_W), .ROW_W(ROW_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .D4        (D4),
        .D5        (D5),
        .D6        (D6),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .win_valid (win_valid),
        .out_eol   (out_eol)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0][9:0] d;
        logic [6:0]      known;
        logic            x;
        logic            y;
        logic            win;
        logic            eol;
    } exp_t;

    exp_t expq [$];
    exp_t held;

    int passes = 0;
    int total  = 0;

    // Reference model: frame position plus, per column, the last six pixels seen there.
    bit         m_active;
    int         m_col;
    int         m_row;
    bit         in_reset;
    logic [9:0] hist [IMG_W][6];
    int         hcnt [IMG_W];

    task automatic chk(string name, bit ok, string detail);
        total++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic string act_str();
        return $sformatf("got D0..D6=%0d,%0d,%0d,%0d,%0d,%0d,%0d X=%0b Y=%0b ov=%0b wv=%0b eol=%0b",
                         D0, D1, D2, D3, D4, D5, D6, X, Y, out_valid, win_valid, out_eol);
    endfunction

    function automatic string exp_str(exp_t e);
        return $sformatf("want D0..D6=%0d,%0d,%0d,%0d,%0d,%0d,%0d known=%b X=%0b Y=%0b wv=%0b eol=%0b",
                         e.d[0], e.d[1], e.d[2], e.d[3], e.d[4], e.d[5], e.d[6], e.known,
                         e.x, e.y, e.win, e.eol);
    endfunction

    function automatic bit data_ok(exp_t e);
        for (int k = 0; k < 7; k++) begin
            if (e.known[k] && (dq[k] !== e.d[k])) return 1'b0;
        end
        return (X === e.x) && (Y === e.y);
    endfunction

    task automatic chk_zero(string name);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 7; k++) if (dq[k] !== 10'd0) ok = 1'b0;
        if ({X, Y, out_valid, win_valid, out_eol} !== 5'b0) ok = 1'b0;
        chk(name, ok, {act_str(), " want all zero"});
    endtask

    // Drive one cycle of input and, if the model accepts it, queue the expected column.
    task automatic send(bit v, bit s, logic [9:0] dat);
        exp_t e;
        int   c;
        @(posedge CLK);
        #1;
        in_valid = v;
        in_sof   = s;
        in_data  = dat;
        if (!in_reset && v && (m_active || s)) begin
            if (s) begin
                m_active = 1'b1;
                m_col    = 0;
                m_row    = 0;
            end
            c          = m_col;
            e          = '0;
            e.d[6]     = dat;
            e.known[6] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (hcnt[c] >= 6 - k) begin
                    e.d[k]     = hist[c][5-k];
                    e.known[k] = 1'b1;
                end
            end
            for (int j = 5; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = dat;
            if (hcnt[c] < 6) hcnt[c]++;
            e.x   = (c % 2) == 0;
            e.y   = (m_row % 2) == 0;
            e.win = (m_row >= 6) && (c >= 6);
            e.eol = (c == IMG_W - 1);
            expq.push_back(e);
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                if (m_row < ROW_MAX) m_row++;
            end
        end
    endtask

    // n raster pixels; seq gives value = raster index, gap_at inserts a 3-cycle stall.
    task automatic pixels(int n, bit first_sof, bit seq, int gap_pct, int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                repeat (3) send(1'b0, 1'b0, 10'($urandom));
            end else if ($urandom_range(99) < gap_pct) begin
                repeat ($urandom_range(1, 3)) send(1'b0, 1'b0, 10'($urandom));
            end
            send(1'b1, first_sof && (i == 0), seq ? 10'(i) : 10'($urandom));
        end
    endtask

    task automatic async_reset(string name);
        send(1'b0, 1'b0, 10'd0);
        send(1'b0, 1'b0, 10'd0);
        #1;
        in_reset = 1'b1;
        RST_N    = 1'b0;
        #1;
        chk_zero(name);
        m_active = 1'b0;
        m_col    = 0;
        m_row    = 0;
        repeat (3) send(1'b1, 1'b0, 10'($urandom));
        in_valid = 1'b0;
        @(posedge CLK);
        #3;
        RST_N    = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: compare each presented column; otherwise outputs must hold with flags low.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                held       = '0;
                held.known = '1;
            end else if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", 1'b0, act_str());
                end else begin
                    e = expq.pop_front();
                    chk("column", data_ok(e) && (win_valid === e.win) && (out_eol === e.eol),
                        {act_str(), " ", exp_str(e)});
                    held = e;
                end
            end else begin
                chk("hold", data_ok(held) && (win_valid === 1'b0) && (out_eol === 1'b0),
                    {act_str(), " ", exp_str(held)});
            end
        end
    end

    initial begin
        RST_N    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        in_reset = 1'b1;
        m_active = 1'b0;
        m_col    = 0;
        m_row    = 0;
        for (int c = 0; c < IMG_W; c++) hcnt[c] = 0;
        #22;
        chk_zero("reset_state");
        @(posedge CLK);
        #3;
        RST_N    = 1'b1;
        in_reset = 1'b0;

        // Pixels without sof in IDLE must be dropped.
        repeat (10) send(1'b1, 1'b0, 10'($urandom));

        // Ramp frame (value = 8*row + col) with a 3-cycle stall at row 2, col 3.
        pixels(10 * IMG_W, 1'b1, 1'b1, 0, 2 * IMG_W + 3);

        // Random frames with random stalls; the last one runs past row saturation.
        pixels(8 * IMG_W, 1'b1, 1'b0, 20, -1);
        pixels(18 * IMG_W, 1'b1, 1'b0, 15, -1);

        // Restart mid-line at row 3, col 4.
        pixels(3 * IMG_W + 4, 1'b1, 1'b1, 10, -1);
        pixels(9 * IMG_W, 1'b1, 1'b1, 10, -1);

        // Asynchronous reset mid-row, then pixels ignored until the next sof.
        pixels(2 * IMG_W + 3, 1'b1, 1'b0, 0, -1);
        async_reset("async_reset_mid_row");
        repeat (12) send(1'b1, 1'b0, 10'($urandom));
        pixels(9 * IMG_W, 1'b1, 1'b0, 20, -1);

        repeat (4) send(1'b0, 1'b0, 10'd0);
        chk("queue_drained", expq.size() == 0, $sformatf("pending=%0d want 0", expq.size()));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/raw_linebuf_7row.md
RAW_LINEBUF_7ROW -- requirements
Module: raw_linebuf_7row

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line (≥8).
REQ-002 Parameter ROW_W, default 12, row counter width.
REQ-003 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  raw Bayer pixel present on in_data this cycle.
REQ-006 Port in_sof  input  1  qualified by in_valid; marks pixel (col 0, row 0) of a frame.
REQ-007 Port in_data  input  10  raw Bayer pixel, raster order.
REQ-008 Port D0..D6  output  10 each  one 7-row column; D6 is the current row, D0 is six rows earlier, same column.
REQ-009 Port X  output  1  column parity of the window centre seen by the downstream 7x7 stage.
REQ-010 Port Y  output  1  row parity of that centre.
REQ-011 Port out_valid  output  1  D0..D6/X/Y carry a new column this cycle.
REQ-012 Port win_valid  output  1  out_valid and a full 7x7 window of the current frame exists (row ≥6, col ≥6).
REQ-013 Port out_eol  output  1  out_valid column is the last of its line.

Function
REQ-014 FSM states: IDLE (discard pixels) and ACTIVE (accept pixels).
REQ-015 IDLE -> ACTIVE on in_valid & in_sof; that pixel is accepted as col 0, row 0.
REQ-016 ACTIVE stays ACTIVE; in_valid & in_sof in ACTIVE restarts at col 0, row 0, even mid-line.
REQ-017 Column counter col: +1 per accepted pixel; at IMG_W-1 it wraps to 0 and row increments.
REQ-018 Row counter row saturates at 2^ROW_W-1; it does not wrap.
REQ-019 Six line memories, each IMG_W x 10, form a cascade addressed by col.
REQ-020 Per accepted pixel: read all six lines at col, then write line k ← old line k+1 (k=0..4) and line 5 ← in_data.
REQ-021 Read and write to the same address in the same cycle are read-before-write.
REQ-022 Outputs are registered with 1-cycle latency: D6 = in_data, D5 = line5 old, ..., D0 = line0 old.
REQ-023 X = ~col[0] and Y = ~row[0] of the accepted pixel; this aligns parity to the 3-column, 3-row-offset centre consumed downstream.
REQ-024 out_valid = registered (accepted pixel).
REQ-025 win_valid = registered (accepted & row≥6 & col≥6).
REQ-026 out_eol = registered (accepted & col==IMG_W-1).
REQ-027 in_valid low: no memory write, counters hold, D0..D6/X/Y hold, out_valid=win_valid=out_eol=0.
REQ-028 Line memories are not reset; rows 0..5 of a frame may carry stale data, flagged only by win_valid=0.

Reset
REQ-029 RST_N low asynchronously forces: state=IDLE, col=0, row=0, D0..D6=0, X=0, Y=0, out_valid=0, win_valid=0, out_eol=0.
REQ-030 Reset mid-frame: after release, pixels are dropped until the next in_sof.
REQ-031 Memory contents are undefined after reset.

Verification (IMG_W=8)
REQ-032 Reset, then in_valid=1, in_sof=0 for 10 cycles -> out_valid stays 0; state stays IDLE.
REQ-033 Frame with pixel value = 8*row+col, sof on first pixel -> at the accepted pixel row 6, col 6 (value 54): next cycle D6=54, D5=46, ..., D0=6, win_valid=1, X=1, Y=1.
REQ-034 Same frame, pixel row 6, col 7 -> out_eol=1, X=0; the next accepted pixel is row 7, col 0 with win_valid=0.
REQ-035 Deassert in_valid for 3 cycles mid-line -> outputs hold, out_valid=0; resuming pixel continues at the next col, with no skip or duplicate.
REQ-036 in_sof asserted at row 3, col 4 -> that pixel maps to row 0, col 0; win_valid=0 until the new row 6, col 6.
REQ-037 RST_N pulsed low asynchronously mid-row -> all outputs 0 immediately, before the next clock edge; after release, pixels are ignored until in_sof.
